instruction_fetch_decode: RTL

Per-core fetch/decode stage sitting directly downstream of the shared instruction memory. It owns the core's program counter, drives one instruction-address port plus a read request, captures the returned 16-bit word, splits it into opcode/operand fields, fetches the second word of two-word instructions (LOAD, JMPZ), and resolves NOP/JMPZ/END internally. All other instructions are presented to the core datapath through a valid/ready handshake, one at a time.

---
 rtl/instruction_fetch_decode.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode stage for one core: owns the PC, reads the shared instruction memory,
// resolves NOP/JMPZ/END locally and hands every other instruction to the datapath.
module instruction_fetch_decode #(
    parameter logic [15:0] RESET_PC  = 16'd0,
    parameter int          MEM_DEPTH = 64
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    output logic        o_mem_rd,
    output logic [15:0] o_instr_addr,
    input  logic [15:0] i_instr_in,
    input  logic        i_z_flag,
    input  logic        i_exec_ready,
    output logic        o_dec_valid,
    output logic [3:0]  o_dec_opcode,
    output logic [4:0]  o_dec_ra,
    output logic [4:0]  o_dec_rb,
    output logic [15:0] o_dec_imm,
    output logic        o_busy,
    output logic        o_halted,
    output logic        o_fault,
    output logic [2:0]  o_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
    localparam logic [2:0] S_IMM_FETCH = 3'd3;
    localparam logic [2:0] S_IMM_WAIT  = 3'd4;
    localparam logic [2:0] S_ISSUE     = 3'd5;
    localparam logic [2:0] S_HALT      = 3'd6;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_END  = 4'd1;
    localparam logic [3:0] OP_LOAD = 4'd4;
    localparam logic [3:0] OP_JMPZ = 4'd15;

    // 17 bits so a depth of 65536 still compares correctly.
    localparam logic [16:0] DEPTH_LIMIT = 17'(MEM_DEPTH);

    // Handshake: o_dec_valid is high for the whole ISSUE state with fields held stable;
    // a cycle with o_dec_valid && i_exec_ready is the transfer, including the first cycle.
    logic [2:0]  r_state;
    logic [15:0] r_pc;
    logic [15:0] r_last_addr;
    logic [3:0]  r_opcode;
    logic [4:0]  r_ra;
    logic [4:0]  r_rb;
    logic [15:0] r_imm;
    logic        r_halted;
    logic        r_fault;

    logic [15:0] w_pc_p1;
    logic [15:0] w_pc_p2;
    logic        w_pc_oob;
    logic        w_pc_p1_oob;
    logic [3:0]  w_in_opcode;
    logic        w_rd_fetch;
    logic        w_rd_imm;

    assign w_pc_p1     = r_pc + 16'd1;
    assign w_pc_p2     = r_pc + 16'd2;
    assign w_pc_oob    = {1'b0, r_pc} >= DEPTH_LIMIT;
    assign w_pc_p1_oob = {1'b0, w_pc_p1} >= DEPTH_LIMIT;
    assign w_in_opcode = i_instr_in[13:10];

    assign w_rd_fetch  = (r_state == S_FETCH) && !w_pc_oob;
    assign w_rd_imm    = (r_state == S_IMM_FETCH) && !w_pc_p1_oob;

    // Address is only driven fresh during a real read; otherwise the last one is held.
    assign o_mem_rd     = w_rd_fetch || w_rd_imm;
    assign o_instr_addr = w_rd_fetch ? r_pc : (w_rd_imm ? w_pc_p1 : r_last_addr);

    assign o_dec_valid  = (r_state == S_ISSUE);
    assign o_dec_opcode = r_opcode;
    assign o_dec_ra     = r_ra;
    assign o_dec_rb     = r_rb;
    assign o_dec_imm    = r_imm;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALT);
    assign o_halted     = r_halted;
    assign o_fault      = r_fault;
    assign o_state      = r_state;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_last_addr <= 16'd0;
            r_opcode    <= 4'd0;
            r_ra        <= 5'd0;
            r_rb        <= 5'd0;
            r_imm       <= 16'd0;
            r_halted    <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_pc    <= RESET_PC;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_pc_oob) begin
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_last_addr <= r_pc;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_opcode <= w_in_opcode;
                    r_ra     <= i_instr_in[9:5];
                    r_rb     <= i_instr_in[4:0];
                    r_imm    <= 16'd0;
                    case (w_in_opcode)
                        OP_LOAD, OP_JMPZ: r_state <= S_IMM_FETCH;
                        OP_NOP: begin
                            r_pc    <= w_pc_p1;
                            r_state <= S_FETCH;
                        end
                        OP_END: begin
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
                        default: r_state <= S_ISSUE;
                    endcase
                end
                S_IMM_FETCH: begin
                    if (w_pc_p1_oob) begin
                        r_fault  <= 1'b1;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_last_addr <= w_pc_p1;
                        r_state     <= S_IMM_WAIT;
                    end
                end
                S_IMM_WAIT: begin
                    if (r_opcode == OP_LOAD) begin
                        r_imm   <= i_instr_in;
                        r_state <= S_ISSUE;
                    end else begin
                        // JMPZ branches on a nonzero result (z_flag low), as SUB;JMPZ loops expect.
                        r_pc    <= i_z_flag ? w_pc_p2 : i_instr_in;
                        r_state <= S_FETCH;
                    end
                end
                S_ISSUE: begin
                    if (i_exec_ready) begin
                        r_pc    <= (r_opcode == OP_LOAD) ? w_pc_p2 : w_pc_p1;
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (i_start) begin
                        r_halted <= 1'b0;
                        r_fault  <= 1'b0;
                        r_pc     <= RESET_PC;
                        r_state  <= S_FETCH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
